// File: rtl/io_timer.sv
// io_timer: bank-decoded 8-bit timer with prescaler, compare match, periodic/one-shot modes and level IRQ.
// Optional input-capture unit is built only when IO_TIMER_CAPTURE_EN is defined.
module io_timer #(
    parameter logic [1:0] BANK = 2'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic [4:0] io_readaddr,
    output logic [7:0] io_readdata,
    input  logic [4:0] io_writeaddr,
    input  logic [7:0] io_writedata,
    input  logic       io_write_en,
    output logic       timer_irq
`ifdef IO_TIMER_CAPTURE_EN
    ,
    input  logic       capture_in
`endif
);

    localparam logic [2:0] OFS_CTRL     = 3'd0;
    localparam logic [2:0] OFS_PRESCALE = 3'd1;
    localparam logic [2:0] OFS_COMPARE  = 3'd2;
    localparam logic [2:0] OFS_COUNT    = 3'd3;
    localparam logic [2:0] OFS_STATUS   = 3'd4;
    localparam logic [2:0] OFS_CAPTURE  = 3'd5;

    // ctrl_q: bit0 EN, bit1 RELOAD, bit2 IE; status_q: bit0 MATCH, bit1 CAPF
    logic [2:0] ctrl_q,     ctrl_d;
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] compare_q,  compare_d;
    logic [7:0] count_q,    count_d;
    logic [1:0] status_q,   status_d;
    logic [7:0] presc_q,    presc_d;
    logic [7:0] rdata_q,    rdata_d;
    logic       irq_q,      irq_d;

    logic       wr_hit_s;
    logic       rd_hit_s;
    logic       run_s;
    logic       tick_s;
    logic       match_set_s;
    logic       cap_edge_s;
    logic [1:0] status_clr_s;
    logic [7:0] capture_rd_s;

`ifdef IO_TIMER_CAPTURE_EN
    logic       sync1_q, sync2_q, sync3_q;
    logic [7:0] capture_q;

    // Two-flop synchronizer plus edge-history flop; CAPTURE loads on every synchronized rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            capture_q <= 8'h00;
        end else begin
            sync1_q <= capture_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (cap_edge_s) begin
                capture_q <= count_q;
            end else begin
                capture_q <= capture_q;
            end
        end
    end

    assign cap_edge_s   = sync2_q & ~sync3_q;
    assign capture_rd_s = capture_q;
`else
    assign cap_edge_s   = 1'b0;
    assign capture_rd_s = 8'h00;
`endif

    function automatic logic [7:0] read_mux(
        input logic [2:0] ofs,
        input logic [2:0] ctrl,
        input logic [7:0] prescale,
        input logic [7:0] compare,
        input logic [7:0] count,
        input logic [1:0] status,
        input logic [7:0] capture
    );
        logic [7:0] val;
        case (ofs)
            OFS_CTRL:     val = {5'd0, ctrl};
            OFS_PRESCALE: val = prescale;
            OFS_COMPARE:  val = compare;
            OFS_COUNT:    val = count;
            OFS_STATUS:   val = {6'd0, status};
            OFS_CAPTURE:  val = capture;
            default:      val = 8'h00;
        endcase
        return val;
    endfunction

    assign wr_hit_s = io_write_en && (io_writeaddr[4:3] == BANK);
    assign rd_hit_s = (io_readaddr[4:3] == BANK);
    assign run_s    = ctrl_q[0] && !pause;
    assign tick_s   = run_s && (presc_q == prescale_q);

    // Timer advance, then software writes layered on top so they win over a same-cycle tick.
    always_comb begin
        ctrl_d       = ctrl_q;
        prescale_d   = prescale_q;
        compare_d    = compare_q;
        count_d      = count_q;
        presc_d      = presc_q;
        match_set_s  = 1'b0;
        status_clr_s = 2'b00;

        if (tick_s) begin
            presc_d = 8'h00;
            if (count_q == compare_q) begin
                match_set_s = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = 8'h00;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                count_d = count_q + 8'd1;
            end
        end else if (run_s) begin
            presc_d = presc_q + 8'd1;
        end else begin
            presc_d = presc_q;
        end

        if (wr_hit_s) begin
            case (io_writeaddr[2:0])
                OFS_CTRL:     ctrl_d     = io_writedata[2:0];
                OFS_PRESCALE: prescale_d = io_writedata;
                OFS_COMPARE:  compare_d  = io_writedata;
                OFS_COUNT: begin
                    count_d = io_writedata;
                    presc_d = 8'h00;
                end
                OFS_STATUS:   status_clr_s = io_writedata[1:0];
                default:      status_clr_s = 2'b00;
            endcase
        end else begin
            status_clr_s = 2'b00;
        end

        // A hardware set outranks a same-cycle write-1-to-clear.
        status_d = (status_q & ~status_clr_s) | {cap_edge_s, match_set_s};
        irq_d    = ctrl_d[2] & (|status_d);

        if (pause) begin
            rdata_d = rdata_q;
        end else if (rd_hit_s) begin
            rdata_d = read_mux(io_readaddr[2:0], ctrl_q, prescale_q, compare_q,
                               count_q, status_q, capture_rd_s);
        end else begin
            rdata_d = 8'h00;
        end
    end

    // Architectural state, read-data and interrupt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= 3'd0;
            prescale_q <= 8'h00;
            compare_q  <= 8'hFF;
            count_q    <= 8'h00;
            status_q   <= 2'b00;
            presc_q    <= 8'h00;
            rdata_q    <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            status_q   <= status_d;
            presc_q    <= presc_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign io_readdata = rdata_q;
    assign timer_irq   = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// Directed self-checking bench for io_timer instantiated on bank 1; inputs driven on the falling edge.
module tb_io_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pause = 1'b0;
    logic [4:0] io_readaddr = 5'd0;
    logic [7:0] io_readdata;
    logic [4:0] io_writeaddr = 5'd0;
    logic [7:0] io_writedata = 8'h00;
    logic       io_write_en = 1'b0;
    logic       timer_irq;
`ifdef IO_TIMER_CAPTURE_EN
    logic       capture_in = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] A_CTRL     = 5'b01_000;
    localparam logic [4:0] A_PRESCALE = 5'b01_001;
    localparam logic [4:0] A_COMPARE  = 5'b01_010;
    localparam logic [4:0] A_COUNT    = 5'b01_011;
    localparam logic [4:0] A_STATUS   = 5'b01_100;
    localparam logic [4:0] A_CAPTURE  = 5'b01_101;
    localparam logic [4:0] A_RSVD     = 5'b01_110;
    localparam logic [4:0] A_B0_COUNT = 5'b00_011;

    io_timer #(.BANK(2'd1)) dut (
        .clk          (clk),
        .reset        (reset),
        .pause        (pause),
        .io_readaddr  (io_readaddr),
        .io_readdata  (io_readdata),
        .io_writeaddr (io_writeaddr),
        .io_writedata (io_writedata),
        .io_write_en  (io_write_en),
        .timer_irq    (timer_irq)
`ifdef IO_TIMER_CAPTURE_EN
        ,
        .capture_in   (capture_in)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge, returns at the following falling edge.
    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        io_writeaddr = a;
        io_writedata = d;
        io_write_en  = 1'b1;
        @(negedge clk);
        io_write_en  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
        io_readaddr = a;
        @(negedge clk);
        check(tag, io_readdata, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        check(tag, {7'd0, timer_irq}, {7'd0, exp});
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values
        check("rst_rdata", io_readdata, 8'h00);
        irq_chk("rst_irq", 1'b0);
        rd_chk("rst_ctrl", A_CTRL, 8'h00);
        rd_chk("rst_presc", A_PRESCALE, 8'h00);
        rd_chk("rst_cmp", A_COMPARE, 8'hFF);
        rd_chk("rst_count", A_COUNT, 8'h00);
        rd_chk("rst_status", A_STATUS, 8'h00);
        rd_chk("rst_capture", A_CAPTURE, 8'h00);

        // Periodic: PRESCALE=3, COMPARE=2 -> match every 12 cycles
        wr(A_PRESCALE, 8'd3);
        wr(A_COMPARE, 8'd2);
        wr(A_CTRL, 8'h07);
        repeat (11) @(negedge clk);
        irq_chk("per_irq_e11", 1'b0);
        @(negedge clk);
        irq_chk("per_irq_e12", 1'b1);
        wr(A_STATUS, 8'h01);
        irq_chk("per_irq_clr", 1'b0);
        repeat (10) @(negedge clk);
        irq_chk("per_irq_e23", 1'b0);
        @(negedge clk);
        irq_chk("per_irq_e24", 1'b1);
        wr(A_CTRL, 8'h00);
        wr(A_STATUS, 8'h01);
        rd_chk("per_count", A_COUNT, 8'h00);
        rd_chk("per_status_clr", A_STATUS, 8'h00);

        // One-shot: PRESCALE=0, COMPARE=4
        wr(A_PRESCALE, 8'd0);
        wr(A_COMPARE, 8'd4);
        wr(A_COUNT, 8'd0);
        wr(A_CTRL, 8'h05);
        repeat (4) @(negedge clk);
        irq_chk("os_irq_e4", 1'b0);
        @(negedge clk);
        irq_chk("os_irq_e5", 1'b1);
        rd_chk("os_ctrl", A_CTRL, 8'h04);
        rd_chk("os_count", A_COUNT, 8'd4);
        rd_chk("os_status", A_STATUS, 8'h01);
        wr(A_STATUS, 8'h01);

        // W1C collides with a match tick: COMPARE=3, matches at E+4 and E+8
        wr(A_COMPARE, 8'd3);
        wr(A_COUNT, 8'd0);
        wr(A_CTRL, 8'h07);
        repeat (4) @(negedge clk);
        irq_chk("w1c_irq_e4", 1'b1);
        repeat (3) @(negedge clk);
        wr(A_STATUS, 8'h01);
        irq_chk("w1c_irq_hold", 1'b1);
        rd_chk("w1c_status_hold", A_STATUS, 8'h01);
        wr(A_STATUS, 8'h01);
        irq_chk("w1c_irq_clr", 1'b0);
        wr(A_CTRL, 8'h00);
        wr(A_STATUS, 8'h01);

        // COUNT write beats a same-cycle tick
        wr(A_COMPARE, 8'hFF);
        wr(A_COUNT, 8'd0);
        wr(A_CTRL, 8'h01);
        repeat (2) @(negedge clk);
        wr(A_COUNT, 8'h50);
        wr(A_CTRL, 8'h00);
        rd_chk("cnt_wr_wins", A_COUNT, 8'h51);

        // Pause freezes prescaler, COUNT and read data
        wr(A_PRESCALE, 8'd3);
        wr(A_COUNT, 8'd0);
        io_readaddr = A_COUNT;
        wr(A_CTRL, 8'h01);
        repeat (5) @(negedge clk);
        pause = 1'b1;
        io_readaddr = A_PRESCALE;
        repeat (10) @(negedge clk);
        check("pause_rdata", io_readdata, 8'd1);
        pause = 1'b0;
        io_readaddr = A_COUNT;
        repeat (3) @(negedge clk);
        check("pause_resume_e18", io_readdata, 8'd1);
        @(negedge clk);
        check("pause_resume_e19", io_readdata, 8'd2);
        wr(A_CTRL, 8'h00);

        // Bank decode and reserved offsets
        wr(A_COUNT, 8'h33);
        wr(A_B0_COUNT, 8'h99);
        rd_chk("bank0_read", A_B0_COUNT, 8'h00);
        rd_chk("bank1_read", A_COUNT, 8'h33);
        wr(A_RSVD, 8'hAA);
        rd_chk("rsvd_read", A_RSVD, 8'h00);

`ifdef IO_TIMER_CAPTURE_EN
        // Capture: edge at E+0.5 lands COUNT value from after E+2
        wr(A_PRESCALE, 8'd0);
        wr(A_STATUS, 8'h03);
        wr(A_COUNT, 8'h20);
        wr(A_CTRL, 8'h05);
        capture_in = 1'b1;
        repeat (3) @(negedge clk);
        wr(A_CTRL, 8'h04);
        rd_chk("cap_value", A_CAPTURE, 8'h22);
        rd_chk("cap_flag", A_STATUS, 8'h02);
        irq_chk("cap_irq", 1'b1);
        capture_in = 1'b0;
        wr(A_STATUS, 8'h03);
        wr(A_CTRL, 8'h00);
`else
        rd_chk("nocap_capture", A_CAPTURE, 8'h00);
`endif

        // Reset mid-count aborts and leaves timer idle
        wr(A_PRESCALE, 8'd0);
        wr(A_COMPARE, 8'd2);
        wr(A_COUNT, 8'd0);
        wr(A_CTRL, 8'h07);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        irq_chk("rst2_irq", 1'b0);
        rd_chk("rst2_ctrl", A_CTRL, 8'h00);
        rd_chk("rst2_cmp", A_COMPARE, 8'hFF);
        rd_chk("rst2_count", A_COUNT, 8'h00);
        rd_chk("rst2_status", A_STATUS, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
